// File: rtl/word_packer_pkg.sv
// -----------------------------------------------------------------------------
// Shared types for the byte-FIFO -> wide-beat packing path.
//
//   fifo_types   : word_t, the FIFO entry type (one byte).
//   packer_types : pk_state_e FSM encoding, the PK_WORDS_MAX limit and
//                  pk_count_width(), which sizes the word counter and len_o.
//
// fifo_types must be compiled before packer_types. Both packages live in this
// file so that order always holds.
// -----------------------------------------------------------------------------

package fifo_types;

  typedef logic [7:0] word_t;

endpackage : fifo_types

package packer_types;

  import fifo_types::word_t;

  // FILL: collecting words into lanes. HOLD: a complete beat is on data_o.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

  // Largest supported beat width, in words.
  localparam int PK_WORDS_MAX = 16;

  // The counter must hold every value from 0 to WORDS inclusive, so it needs
  // $clog2(WORDS+1) bits rather than $clog2(WORDS).
  function automatic int pk_count_width(input int words);
    return $clog2(words + 1);
  endfunction

endpackage : packer_types

// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
//
// Pops byte entries from the upstream FIFO using its valid/yumi handshake and
// packs WORDS consecutive entries into one wide beat. The beat is offered
// downstream on a valid/ready handshake. While a beat is waiting, the FIFO is
// popped only if that beat retires in the same cycle. The retiring cycle can
// also load the first word of the next beat, so a continuous stream moves
// WORDS words every WORDS cycles with no bubble.
//
// Parameters
//   WORDS      words per beat, legal range 2..PK_WORDS_MAX (16)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   valid_i    FIFO has data (head entry on data_i)
//   data_i     FIFO head entry (word_t)
//   yumi_o     pop the FIFO this cycle. Combinational, and never high while
//              valid_i is low.
//   valid_o    packed beat available (registered)
//   data_o     packed beat. Word k is at data_o[8k +: 8], and k=0 is the
//              first word popped. Lanes not written in this beat read 0.
//   len_o      number of valid words in the beat, 1..WORDS (registered)
//   ready_i    downstream takes the beat when valid_o && ready_i
//   flush_i    close a partial beat early. This port exists only when
//              PACKER_FLUSH_EN is defined.
//
// Configuration
//   PACKER_FLUSH_EN  When defined, the flush_i port is added. A flush in FILL
//                    includes any pop in the same cycle and then presents
//                    whatever has been collected. If nothing has been
//                    collected, the flush is ignored. A flush in HOLD is also
//                    ignored. When the macro is undefined, len_o equals WORDS
//                    whenever valid_o is 1.
// -----------------------------------------------------------------------------

module word_packer
  import fifo_types::*;
  import packer_types::*;
#(
  parameter  int WORDS = 4,
  localparam int CW    = pk_count_width(WORDS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_i,
  input  word_t              data_i,
  output logic               yumi_o,
  output logic               valid_o,
  output logic [8*WORDS-1:0] data_o,
  output logic [CW-1:0]      len_o,
  input  logic               ready_i
`ifdef PACKER_FLUSH_EN
  ,
  input  logic               flush_i
`endif
);

  pk_state_e           state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       count_inc;
  word_t [WORDS-1:0]   lanes_q, lanes_d;
  logic [CW-1:0]       len_q, len_d;
  logic                valid_q, valid_d;

  // Pop whenever the FIFO has data and there is room for it. In FILL a lane is
  // always free. In HOLD there is room only if the current beat retires in
  // this cycle. Neither case needs to know the counter value.
  assign yumi_o = valid_i && ((state_q == FILL) || ((state_q == HOLD) && ready_i));

  // Count after this cycle's pop. This value is meaningful only in FILL.
  assign count_inc = count_q + CW'(yumi_o);

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below leaves a signal unassigned and no latch is
    // inferred.
    state_d = state_q;
    count_d = count_q;
    lanes_d = lanes_q;
    len_d   = len_q;
    valid_d = valid_q;

    case (state_q)
      FILL: begin
        // Lane write enable is a decode of the counter. The loop avoids
        // indexing with a counter that is one bit wider than the lane index.
        if (yumi_o) begin
          for (int k = 0; k < WORDS; k++) begin
            if (count_q == CW'(k)) lanes_d[k] = data_i;
          end
        end
        count_d = count_inc;

        if (count_inc == CW'(WORDS)) begin
          // The last word fills the beat. A flush in this same cycle changes
          // nothing, because the beat is already full.
          state_d = HOLD;
          len_d   = CW'(WORDS);
          valid_d = 1'b1;
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_i && (count_inc != '0)) begin
          // A partial beat closes here. Any pop in this cycle is already
          // counted in count_inc.
          state_d = HOLD;
          len_d   = count_inc;
          valid_d = 1'b1;
        end
`endif
      end

      HOLD: begin
        // valid_o depends only on state, so the beat is stable until ready_i.
        if (ready_i) begin
          state_d = FILL;
          valid_d = 1'b0;
          len_d   = '0;
          lanes_d = '0;
          if (valid_i) begin
            // Zero-bubble refill: the word popped while the beat retires
            // becomes lane 0 of the next beat.
            lanes_d[0] = data_i;
            count_d    = CW'(1);
          end else begin
            count_d    = '0;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // NOTE: the lane storage is reset along with the control state. data_o must
  // read 0 after reset, and a reset in the middle of a beat must discard the
  // partial data, so the lanes cannot be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      count_q <= '0;
      lanes_q <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: registers update only with non-blocking assignments. Every
      // next-state value is computed beforehand in always_comb.
      state_q <= state_d;
      count_q <= count_d;
      lanes_q <= lanes_d;
      len_q   <= len_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = lanes_q;
  assign len_o   = len_q;

endmodule : word_packer
